digit_serial_adder: RTL and testbench

Parametrised successor to the 4-bit combinational adder: a digit-serial WIDTH-bit add/subtract/accumulate engine that processes DIGIT bits per clock through one shared DIGIT-bit adder slice. It sits behind the TinyTapeout top-level wrapper, which maps its ports onto the ui/uo/uio pins. It adds subtraction, a running accumulator, carry and signed-overflow flags, and a start/busy/done handshake.

---
 rtl/adder_pkg.sv | 29 ++
 rtl/digit_add_slice.sv | 21 ++
 rtl/digit_serial_adder.sv | 142 ++++++++++++++
 tb/tb_digit_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial add/sub/accumulate engine.
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Single-digit configurations still need a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_add_slice.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its top bit.
module digit_add_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum   = full[DIGIT-1:0];
  assign cout  = full[DIGIT];
  // Carry into the MSB falls out of the MSB sum bit without a second adder.
  assign c_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit add/sub/accumulate engine, one DIGIT-bit slice per clock.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, req_mode;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d;
  logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d;

  logic [DIGIT-1:0]       sum;
  logic                   cout, c_msb;
  logic [WIDTH+DIGIT-1:0] sr_cat;
  logic [WIDTH-1:0]       sr_nxt;

  digit_add_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (cy_q),
    .sum  (sum),
    .cout (cout),
    .c_msb(c_msb)
  );

  // New digits enter at the top so digit 0 lands at the LSB after NDIG shifts.
  assign sr_cat   = {sum, sr_q};
  assign sr_nxt   = sr_cat[WIDTH+DIGIT-1:DIGIT];
  assign req_mode = mode_e'(mode);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (ena) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start) begin
            mode_d = req_mode;
            a_d    = op_a;
            cnt_d  = '0;
            cy_d   = (req_mode == MODE_SUB);
            case (req_mode)
              MODE_SUB: b_d = ~op_b;
              MODE_ACC: b_d = acc_q;
              default:  b_d = op_b;
            endcase
            if (req_mode == MODE_CLR) begin
              state_d = ST_DONE;
              res_d   = '0;
              acc_d   = '0;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          a_d   = a_q >> DIGIT;
          b_d   = b_q >> DIGIT;
          sr_d  = sr_nxt;
          cy_d  = cout;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            res_d   = sr_nxt;
            carry_d = cout;
            ovf_d   = cout ^ c_msb;
            if (mode_q == MODE_ACC) acc_d = sr_nxt;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADD;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder at WIDTH=16, DIGIT=4.
module tb_digit_serial_adder;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n, ena, start;
  logic [1:0]   mode;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, carry, overflow;
  logic [W-1:0] result;

  int n_chk = 0;
  int n_err = 0;

  digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start),
    .mode    (mode),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; k returns edges after the accepting edge until done is seen.
  task automatic do_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int k);
    mode = m; op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) chk("timeout", 32'(k), 32'd0);
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] r, input logic c, input logic o);
    chk({tag, "_res"}, 32'(result), 32'(r));
    chk({tag, "_cy"},  32'(carry), 32'(c));
    chk({tag, "_ov"},  32'(overflow), 32'(o));
  endtask

  initial begin
    int k;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'b00; op_a = '0; op_b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // ADD with busy/done timing
    mode = 2'b00; op_a = 16'h1234; op_b = 16'h0FFF; start = 1'b1;
    step();
    start = 1'b0;
    chk("add_busy0", 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 20) begin
      step();
      k++;
    end
    chk("add_lat", 32'(k), 32'd4);
    chk_res("add1", 16'h2233, 1'b0, 1'b0);
    chk("add_busy_dn", 32'(busy), 32'd0);
    step();
    chk("add_done_pulse", 32'(done), 32'd0);

    do_op(2'b00, 16'hFFFF, 16'h0001, k);
    chk_res("add_wrap", 16'h0000, 1'b1, 1'b0);
    do_op(2'b00, 16'h7FFF, 16'h0001, k);
    chk_res("add_ovf", 16'h8000, 1'b0, 1'b1);
    do_op(2'b01, 16'h0005, 16'h0007, k);
    chk_res("sub_neg", 16'hFFFE, 1'b0, 1'b0);
    do_op(2'b01, 16'h8000, 16'h0001, k);
    chk_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

    // CLR then three back-to-back ACCs with start held high
    mode = 2'b11; op_a = 16'h0100; op_b = 16'hDEAD; start = 1'b1;
    step();
    chk("clr_done", 32'(done), 32'd1);
    chk("clr_busy", 32'(busy), 32'd0);
    chk_res("clr", 16'h0000, 1'b0, 1'b0);
    mode = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("acc_busy", 32'(busy), 32'd1);
      repeat (4) step();
      chk("acc_done", 32'(done), 32'd1);
      chk("acc_res", 32'(result), 32'(i * 16'h0100));
    end
    start = 1'b0;
    step();
    chk("acc_idle", 32'(done), 32'd0);

    // start held and operands changed during RUN are ignored
    mode = 2'b00; op_a = 16'h00AA; op_b = 16'h0055; start = 1'b1;
    step();
    op_a = 16'hFFFF; op_b = 16'hFFFF; mode = 2'b11;
    repeat (3) step();
    start = 1'b0;
    step();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_res", 32'(result), 32'h00FF);
    step();

    // two-cycle ena drop mid-RUN stretches latency to 6
    mode = 2'b00; op_a = 16'h00AA; op_b = 16'h0055; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    ena = 1'b0;
    step(); step();
    chk("ena_frozen", 32'(busy), 32'd1);
    ena = 1'b1;
    k = 2;
    while (!done && k < 20) begin
      step();
      k++;
    end
    chk("ena_lat", 32'(k + 2), 32'd6);
    chk("ena_res", 32'(result), 32'h00FF);
    step();

    // async reset mid-ADD; acc (0x0300) must also clear
    mode = 2'b00; op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_res", 32'(result), 32'd0);
    chk("mrst_cy", 32'(carry), 32'd0);
    #2 rst_n = 1'b1;
    step();
    do_op(2'b10, 16'h0001, 16'h0000, k);
    chk("post_acc", 32'(result), 32'h0001);
    do_op(2'b00, 16'h0001, 16'h0001, k);
    chk_res("post_add", 16'h0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
